// File: rtl/mul_seq_ctrl.sv
`timescale 1ns/1ps
// mul_seq_ctrl: multi-cycle sequencer for the EX-stage radix-2 Booth
// multiplier (RV32M MUL, MULH, MULHSU, MULHU).
// One request is accepted in IDLE. RUN retires one Booth pair per cycle,
// and DONE presents the selected half of the 64-bit product for one cycle.
// Optional build macro: MUL_EARLY_OUT_EN. When it is defined, RUN ends as
// soon as the remaining multiplier bits are uniform.
module mul_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            flush,
  output logic            stall,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data
);

  localparam int EXT_W = XLEN + 1;       // 33-bit extended operands
  localparam int ACC_W = 2 * EXT_W;      // 66-bit accumulator
  localparam logic [5:0] K_LAST = 6'(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  state_t           state;
  logic [5:0]       k;
  logic [1:0]       op_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] mcand;      // multiplicand, already shifted left by k
  logic [EXT_W:0]   mplr;       // {b[32:0], b[-1]}, shifted right by k
  logic             rsp_valid_q;

  logic             accept;
  logic             rs1_signed;
  logic             rs2_signed;
  logic [EXT_W-1:0] rs1_ext;
  logic [EXT_W-1:0] rs2_ext;
  logic [ACC_W-1:0] acc_next;
  logic             finish;

  // Handshake and stall are combinational. The pipeline must freeze in the
  // same cycle that the request is taken. DONE does not stall, so the
  // pipeline advances while the result is written back.
  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready && !flush;
  assign stall     = (state == RUN) || accept;
  // A flush that lands in the DONE cycle kills the pulse it coincides with.
  assign rsp_valid = rsp_valid_q && !flush;

  // Extend the operands to 33 bits so that every op becomes one signed
  // 33x33 multiply.
  assign rs1_signed = (req_op == OP_MULH) || (req_op == OP_MULHSU);
  assign rs2_signed = (req_op == OP_MULH);
  assign rs1_ext    = {rs1_signed & req_rs1[XLEN-1], req_rs1};
  assign rs2_ext    = {rs2_signed & req_rs2[XLEN-1], req_rs2};

  // Booth step for the current pair (b[k], b[k-1]).
  // NOTE: every output of a combinational block gets a default first, so an
  // unlisted case cannot leave it unassigned and infer a latch.
  always_comb begin
    acc_next = acc;
    case (mplr[1:0])
      2'b01:   acc_next = acc + mcand;
      2'b10:   acc_next = acc - mcand;
      default: acc_next = acc;
    endcase
  end

  // Decide whether the pair being processed is the last one.
`ifdef MUL_EARLY_OUT_EN
  // mplr is arithmetic-shifted, so its upper bits copy b[32]. Uniform
  // mplr[33:1] means b[32:k] are all equal, and every later pair is a no-op.
  logic rest_uniform;
  assign rest_uniform = (&mplr[EXT_W:1]) || !(|mplr[EXT_W:1]);
  assign finish       = (k == K_LAST) || rest_uniform;
`else
  assign finish = (k == K_LAST);
`endif

  // Sequencer FSM with registered datapath and response outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values no matter how the statements are ordered.
  // NOTE: the datapath registers are reset as well. A reset in the middle
  // of an operation leaves no stale partial product behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      op_q        <= OP_MUL;
      acc         <= '0;
      mcand       <= '0;
      mplr        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= req_op;
            mcand <= {{EXT_W{rs1_ext[EXT_W-1]}}, rs1_ext};
            mplr  <= {rs2_ext, 1'b0};
            acc   <= '0;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            mplr  <= {mplr[EXT_W], mplr[EXT_W:1]};
            if (finish) begin
              state       <= DONE;
              rsp_valid_q <= 1'b1;
              rsp_data    <= (op_q == OP_MUL) ? acc_next[XLEN-1:0]
                                              : acc_next[2*XLEN-1:XLEN];
            end else begin
              k <= k + 6'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
`timescale 1ns/1ps
// tb_mul_seq_ctrl: scoreboard bench for mul_seq_ctrl.
// The stimulus pushes the expected result and latency at acceptance. A
// separate monitor pops and compares them on every rsp_valid.
module tb_mul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        flush;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  mul_seq_ctrl #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .flush     (flush),
    .stall     (stall),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  typedef struct {
    logic [31:0] data;
    int          accept_cyc;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [31:0] last_rsp = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference model. Each operand is widened according to its signedness,
  // and one signed product is taken.
  function automatic logic [31:0] model_data(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [65:0] sa, sb, p;
    sa = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
    sb = (op == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Number of RUN cycles. The default build always uses 33. With early out,
  // RUN stops after the first pair k whose b[32:k] bits are all equal.
  function automatic int model_runs(input logic [1:0] op, input logic [31:0] b);
    logic [32:0] bx;
    bx = {(op == 2'b01) & b[31], b};
`ifdef MUL_EARLY_OUT_EN
    for (int kk = 0; kk < 32; kk++) begin
      logic same;
      same = 1'b1;
      for (int j = kk; j <= 32; j++) if (bx[j] != bx[32]) same = 1'b0;
      if (same) return kk + 1;
    end
`else
    if (bx[0] === 1'bx) return 0;
`endif
    return 33;
  endfunction

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_data), 64'hDEAD_0000_0000);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_data", 64'(rsp_data), 64'(e.data));
        check("latency", 64'(cyc - e.accept_cyc), 64'(e.lat));
        last_rsp = rsp_data;
      end
    end
  end

  // Present a request at a negedge and hold it until req_ready allows
  // acceptance. Returns at the negedge after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_rsp, input bit hold);
    exp_t e;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_valid = 1'b1;
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      check("accept_timeout", 64'(req_ready), 64'h1);
    end else if (expect_rsp) begin
      e.data       = model_data(op, a, b);
      e.accept_cyc = cyc + 1;
      e.lat        = model_runs(op, b);
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'h0);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'(1 << $urandom_range(0, 31));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int stall_cnt;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_rs1   = 32'h0;
    req_rs2   = 32'h0;
    flush     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'h1);
    check("reset_stall", 64'(stall), 64'h0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset_rsp_data", 64'(rsp_data), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL 7 x -3: stall is high in the accept cycle and all 33 RUN cycles,
    // and low in DONE.
    req_op = 2'b00; req_rs1 = 32'd7; req_rs2 = 32'hFFFF_FFFD; req_valid = 1'b1;
    #1 check("stall_accept_cycle", 64'(stall), 64'h1);
    issue(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);
    stall_cnt = 0;
    for (int i = 0; i < 60 && !rsp_valid; i++) begin
      stall_cnt += int'(stall);
      @(negedge clk);
    end
    check("stall_run_cycles", 64'(stall_cnt), 64'(model_runs(2'b00, 32'hFFFF_FFFD)));
    check("stall_done_cycle", 64'(stall), 64'h0);
    drain();

    // Sign-handling corners for each high-half op.
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
    issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(2'b00, 32'd5, 32'd2, 1'b1, 1'b0);
    issue(2'b00, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drain();

    // A flush in RUN cycle 10 aborts quietly and leaves rsp_data unchanged.
    issue(2'b00, 32'h1234_5678, 32'd1, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_req_ready", 64'(req_ready), 64'h1);
    check("flush_stall", 64'(stall), 64'h0);
    check("flush_rsp_data_held", 64'(rsp_data), 64'(last_rsp));
    // A request presented together with a flush in IDLE is dropped.
    req_valid = 1'b1; flush = 1'b1; req_op = 2'b00; req_rs1 = 32'd9; req_rs2 = 32'd9;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_drop", 64'(req_ready), 64'h1);
    issue(2'b00, 32'd3, 32'd4, 1'b1, 1'b0);
    drain();

    // Asynchronous reset in RUN cycle 5.
    issue(2'b01, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 64'(req_ready), 64'h1);
    check("midrst_stall", 64'(stall), 64'h0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("midrst_rsp_data", 64'(rsp_data), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(2'b00, 32'd2, 32'd2, 1'b1, 1'b0);
    drain();

    // req_valid held high across three back-to-back requests.
    issue(2'b00, 32'hCAFE_0001, 32'h0000_0100, 1'b1, 1'b1);
    issue(2'b01, 32'h7FFF_FFFF, 32'h8000_0001, 1'b1, 1'b1);
    issue(2'b11, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 1'b0);
    drain();

    // Randomized operations with random idle gaps.
    for (int n = 0; n < 24; n++) begin
      issue(2'($urandom_range(0, 3)), pick(), pick(), 1'b1, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
